// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - PS/2 line inputs and decoded key outputs
interface ps2_keyboard_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       newKey;
  logic [7:0] keyCode;
  logic       extended;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  newKey, keyCode, extended, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output newKey, keyCode, extended, frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver with E0/F0 prefix filtering
module ps2_keyboard_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             reset,
  ps2_keyboard_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          clk_f_q, clk_f_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic          perr_q, perr_d;
  logic          e0_q, e0_d, f0_q, f0_d;
  logic          new_key_q, new_key_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          extended_q, extended_d;
  logic          frame_err_q, frame_err_d;
  logic          evt;
  logic          timeout;

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    clk_f_d   = clk_f_q;
    flt_cnt_d = '0;
    if (clk_s2_q != clk_f_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_f_d = clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  assign evt = clk_f_q & ~clk_f_d;

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    byte_valid_d = 1'b0;
    perr_d       = 1'b0;
    timeout      = 1'b0;
    to_cnt_d     = (state_q == IDLE || evt) ? '0 : to_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (evt && !dat_s2_q) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (evt) begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (evt) begin
          par_ok_d = ^{shift_q, dat_s2_q};
          state_d  = STOP;
        end
      end
      STOP: begin
        if (evt) begin
          byte_valid_d = dat_s2_q & par_ok_q;
          perr_d       = ~(dat_s2_q & par_ok_q);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !evt && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d  = IDLE;
      to_cnt_d = '0;
      timeout  = 1'b1;
    end
  end

  // A break code (F0 xx) swallows the next byte; errors drop any pending prefix.
  always_comb begin
    new_key_d   = 1'b0;
    frame_err_d = perr_q | timeout;
    key_code_d  = key_code_q;
    extended_d  = extended_q;
    e0_d        = e0_q;
    f0_d        = f0_q;
    if (frame_err_d) begin
      e0_d = 1'b0;
      f0_d = 1'b0;
    end else if (byte_valid_q) begin
      if (shift_q == 8'hE0) begin
        e0_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        f0_d = 1'b1;
      end else begin
        if (!f0_q) begin
          new_key_d  = 1'b1;
          key_code_d = shift_q;
          extended_d = e0_q;
        end
        e0_d = 1'b0;
        f0_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      clk_f_q      <= 1'b1;
      flt_cnt_q    <= '0;
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      e0_q         <= 1'b0;
      f0_q         <= 1'b0;
      new_key_q    <= 1'b0;
      key_code_q   <= 8'h00;
      extended_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_s1_q     <= bus.ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= bus.ps2_data;
      dat_s2_q     <= dat_s1_q;
      clk_f_q      <= clk_f_d;
      flt_cnt_q    <= flt_cnt_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      perr_q       <= perr_d;
      e0_q         <= e0_d;
      f0_q         <= f0_d;
      new_key_q    <= new_key_d;
      key_code_q   <= key_code_d;
      extended_q   <= extended_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.newKey    = new_key_q;
  assign bus.keyCode   = key_code_q;
  assign bus.extended  = extended_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
  localparam int HALF = 30;
  localparam int FLT  = 8;
  localparam int TO   = 1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_keyboard_rx_if bus();

  ps2_keyboard_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int nk_cnt = 0, fe_cnt = 0, ovl_cnt = 0, wide_cnt = 0;
  logic [7:0] last_code = 8'h00;
  logic last_ext = 1'b0;
  logic nk_prev = 1'b0, fe_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.newKey) begin
      nk_cnt++;
      last_code = bus.keyCode;
      last_ext  = bus.extended;
    end
    if (bus.frame_err) fe_cnt++;
    if (bus.newKey && bus.frame_err) ovl_cnt++;
    if ((bus.newKey && nk_prev) || (bus.frame_err && fe_prev)) wide_cnt++;
    nk_prev = bus.newKey;
    fe_prev = bus.frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    bus.ps2_data = b;
    if (glitch) begin
      wait_cycles(14);
      bus.ps2_clk = 1'b0;
      wait_cycles(FLT - 2);
      bus.ps2_clk = 1'b1;
      wait_cycles(HALF - 14 - (FLT - 2));
    end else begin
      wait_cycles(HALF);
    end
    bus.ps2_clk = 1'b0;
    wait_cycles(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                            input bit glitch, input int gap);
    logic par;
    par = ~(^b) ^ bad_par;
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
    drive_bit(par, glitch);
    drive_bit(stop, glitch);
    bus.ps2_data = 1'b1;
    wait_cycles(gap);
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic test_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b0;
    wait_cycles(5);
    n_cmp++; if (bus.newKey !== 1'b0) begin n_bad++; $display("FAIL reset_newKey: got %b, expected 0", bus.newKey); end
    n_cmp++; if (bus.keyCode !== 8'h00) begin n_bad++; $display("FAIL reset_keyCode: got %h, expected 00", bus.keyCode); end
    n_cmp++; if (bus.extended !== 1'b0) begin n_bad++; $display("FAIL reset_extended: got %b, expected 0", bus.extended); end
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b, expected 0", bus.frame_err); end
    reset = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_reset_midframe();
    int nk0, fe0;
    send_frame(8'h5A, 0, 1'b1, 0, 4 * HALF);
    n_cmp++; if (last_code !== 8'h5A) begin n_bad++; $display("FAIL pre_reset_code: got %h, expected 5A", last_code); end
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    reset = 1'b0;
    wait_cycles(10);
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    wait_cycles(20);
    n_cmp++; if (bus.newKey !== 1'b0) begin n_bad++; $display("FAIL midreset_newKey: got %b, expected 0", bus.newKey); end
    n_cmp++; if (bus.keyCode !== 8'h00) begin n_bad++; $display("FAIL midreset_keyCode: got %h, expected 00", bus.keyCode); end
    n_cmp++; if (bus.extended !== 1'b0) begin n_bad++; $display("FAIL midreset_extended: got %b, expected 0", bus.extended); end
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL midreset_frame_err: got %b, expected 0", bus.frame_err); end
    nk0 = nk_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 0, 1'b1, 0, 4 * HALF);
    n_cmp++; if (nk_cnt - nk0 !== 1) begin n_bad++; $display("FAIL after_reset_nk: got %0d, expected 1", nk_cnt - nk0); end
    n_cmp++; if (last_code !== 8'h1C) begin n_bad++; $display("FAIL after_reset_code: got %h, expected 1C", last_code); end
    n_cmp++; if (last_ext !== 1'b0) begin n_bad++; $display("FAIL after_reset_ext: got %b, expected 0", last_ext); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL after_reset_fe: got %0d, expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_extended();
    int nk0, fe0;
    nk0 = nk_cnt; fe0 = fe_cnt;
    send_frame(8'hE0, 0, 1'b1, 0, 4 * HALF);
    n_cmp++; if (nk_cnt - nk0 !== 0) begin n_bad++; $display("FAIL e0_no_strobe: got %0d, expected 0", nk_cnt - nk0); end
    send_frame(8'h74, 0, 1'b1, 0, 4 * HALF);
    n_cmp++; if (nk_cnt - nk0 !== 1) begin n_bad++; $display("FAIL ext_nk: got %0d, expected 1", nk_cnt - nk0); end
    n_cmp++; if (last_code !== 8'h74) begin n_bad++; $display("FAIL ext_code: got %h, expected 74", last_code); end
    n_cmp++; if (last_ext !== 1'b1) begin n_bad++; $display("FAIL ext_flag: got %b, expected 1", last_ext); end
    n_cmp++; if (bus.extended !== 1'b1) begin n_bad++; $display("FAIL ext_held: got %b, expected 1", bus.extended); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL ext_fe: got %0d, expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_break();
    int nk0, fe0;
    nk0 = nk_cnt; fe0 = fe_cnt;
    send_frame(8'hE0, 0, 1'b1, 0, 4 * HALF);
    send_frame(8'hF0, 0, 1'b1, 0, 4 * HALF);
    send_frame(8'h74, 0, 1'b1, 0, 4 * HALF);
    n_cmp++; if (nk_cnt - nk0 !== 0) begin n_bad++; $display("FAIL break_nk: got %0d, expected 0", nk_cnt - nk0); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL break_fe: got %0d, expected 0", fe_cnt - fe0); end
    send_frame(8'h6B, 0, 1'b1, 0, 4 * HALF);
    n_cmp++; if (nk_cnt - nk0 !== 1) begin n_bad++; $display("FAIL after_break_nk: got %0d, expected 1", nk_cnt - nk0); end
    n_cmp++; if (last_code !== 8'h6B) begin n_bad++; $display("FAIL after_break_code: got %h, expected 6B", last_code); end
    n_cmp++; if (last_ext !== 1'b0) begin n_bad++; $display("FAIL after_break_ext: got %b, expected 0", last_ext); end
  endtask

  task automatic test_frame_errors();
    int nk0, fe0;
    nk0 = nk_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1, 1'b1, 0, 4 * HALF);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL parity_fe: got %0d, expected 1", fe_cnt - fe0); end
    n_cmp++; if (nk_cnt - nk0 !== 0) begin n_bad++; $display("FAIL parity_nk: got %0d, expected 0", nk_cnt - nk0); end
    send_frame(8'h1C, 0, 1'b1, 0, 4 * HALF);
    n_cmp++; if (nk_cnt - nk0 !== 1) begin n_bad++; $display("FAIL recover_nk: got %0d, expected 1", nk_cnt - nk0); end
    n_cmp++; if (last_code !== 8'h1C) begin n_bad++; $display("FAIL recover_code: got %h, expected 1C", last_code); end
    send_frame(8'h1C, 0, 1'b0, 0, 4 * HALF);
    n_cmp++; if (fe_cnt - fe0 !== 2) begin n_bad++; $display("FAIL stop_fe: got %0d, expected 2", fe_cnt - fe0); end
    n_cmp++; if (nk_cnt - nk0 !== 1) begin n_bad++; $display("FAIL stop_nk: got %0d, expected 1", nk_cnt - nk0); end
    // A frame error between E0 and the key must drop the extended prefix.
    send_frame(8'hE0, 0, 1'b1, 0, 4 * HALF);
    send_frame(8'h33, 1, 1'b1, 0, 4 * HALF);
    send_frame(8'h74, 0, 1'b1, 0, 4 * HALF);
    n_cmp++; if (last_code !== 8'h74) begin n_bad++; $display("FAIL err_prefix_code: got %h, expected 74", last_code); end
    n_cmp++; if (last_ext !== 1'b0) begin n_bad++; $display("FAIL err_prefix_ext: got %b, expected 0", last_ext); end
  endtask

  task automatic test_timeout();
    int nk0, fe0;
    nk0 = nk_cnt; fe0 = fe_cnt;
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    bus.ps2_data = 1'b1;
    wait_cycles(TO + 10 + 2 * HALF);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL timeout_fe: got %0d, expected 1", fe_cnt - fe0); end
    n_cmp++; if (nk_cnt - nk0 !== 0) begin n_bad++; $display("FAIL timeout_nk: got %0d, expected 0", nk_cnt - nk0); end
    send_frame(8'h72, 0, 1'b1, 0, 4 * HALF);
    n_cmp++; if (nk_cnt - nk0 !== 1) begin n_bad++; $display("FAIL post_timeout_nk: got %0d, expected 1", nk_cnt - nk0); end
    n_cmp++; if (last_code !== 8'h72) begin n_bad++; $display("FAIL post_timeout_code: got %h, expected 72", last_code); end
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL post_timeout_fe: got %0d, expected 1", fe_cnt - fe0); end
  endtask

  task automatic test_glitch();
    int nk0, fe0;
    nk0 = nk_cnt; fe0 = fe_cnt;
    for (int g = 0; g < 3; g++) begin
      bus.ps2_data = (g == 1) ? 1'b0 : 1'b1;
      bus.ps2_clk = 1'b0;
      wait_cycles(FLT - 2);
      bus.ps2_clk = 1'b1;
      wait_cycles(3 * HALF);
    end
    bus.ps2_data = 1'b1;
    wait_cycles(TO + 50);
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL idle_glitch_fe: got %0d, expected 0", fe_cnt - fe0); end
    send_frame(8'h75, 0, 1'b1, 1, 4 * HALF);
    n_cmp++; if (nk_cnt - nk0 !== 1) begin n_bad++; $display("FAIL glitch_nk: got %0d, expected 1", nk_cnt - nk0); end
    n_cmp++; if (last_code !== 8'h75) begin n_bad++; $display("FAIL glitch_code: got %h, expected 75", last_code); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL glitch_fe: got %0d, expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    int nk0;
    logic [7:0] seen [3];
    logic [7:0] exp_codes [3];
    exp_codes[0] = 8'h1D; exp_codes[1] = 8'h24; exp_codes[2] = 8'h2D;
    nk0 = nk_cnt;
    for (int i = 0; i < 3; i++) begin
      send_frame(exp_codes[i], 0, 1'b1, 0, HALF);
      seen[i] = last_code;
    end
    wait_cycles(4 * HALF);
    n_cmp++; if (nk_cnt - nk0 !== 3) begin n_bad++; $display("FAIL b2b_nk: got %0d, expected 3", nk_cnt - nk0); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (seen[i] !== exp_codes[i]) begin
        n_bad++;
        $display("FAIL b2b_code%0d: got %h, expected %h", i, seen[i], exp_codes[i]);
      end
    end
  endtask

  task automatic test_invariants();
    n_cmp++; if (ovl_cnt !== 0) begin n_bad++; $display("FAIL strobe_overlap: got %0d, expected 0", ovl_cnt); end
    n_cmp++; if (wide_cnt !== 0) begin n_bad++; $display("FAIL strobe_width: got %0d wide cycles, expected 0", wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_extended();
    test_break();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data lines and assembles bytes. Tracks the E0 (extended) and F0 (break) prefixes so that only make codes reach the output. Emits a one-cycle newKey strobe with an 8-bit keyCode. Sits directly upstream of the arrow-key-to-move stage, which consumes newKey/keyCode (arrow keys arrive as E0-prefixed codes 0x74/0x72/0x75/0x6B).

Parameters:
FILTER_LEN, 8, consecutive equal clk samples required before the filtered ps2_clk changes level (glitch filter).
TIMEOUT_CYC, 50000, clk cycles allowed between falling edges inside a frame before the frame is aborted (1 ms at 50 MHz).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk
ps2_data  input  1  raw PS/2 data line, asynchronous to clk
newKey  output  1  one-cycle strobe: a new make code is on keyCode
keyCode  output  8  last make scan code; held until the next newKey
extended  output  1  1 if the current keyCode was E0-prefixed; updated with keyCode
frame_err  output  1  one-cycle strobe on parity, stop-bit or timeout error

Behaviour:
- Reset (reset=0, asynchronous): sync and filter flops = 1, FSM = IDLE, counters = 0, e0_seen = f0_seen = 0, newKey = 0, keyCode = 0x00, extended = 0, frame_err = 0. Reset mid-frame discards all partial data.
- Input sync: 2-flop synchronizer on each line. Filtered clock changes only after FILTER_LEN consecutive identical synced samples.
- Sample event: filtered clock 1->0. ps2_data (synced) is sampled in that same cycle.
- Frame: start(0), D0..D7 LSB first, odd parity, stop(1).
- FSM:
  - IDLE: on an event with data=0, go to DATA with bitcnt=0. An event with data=1 is ignored.
  - DATA: shift the bit in. After the 8th bit, go to PARITY.
  - PARITY: record parity_ok = (XOR of 8 data bits and parity bit) == 1. Go to STOP.
  - STOP: if stop=1 and parity_ok, pulse internal byte_valid. Otherwise pulse frame_err. Return to IDLE in both cases.
- Timeout: the counter clears on every event and in IDLE. In DATA/PARITY/STOP, reaching TIMEOUT_CYC-1 with no event returns the FSM to IDLE, pulses frame_err and discards the byte.
- Prefix decode, on byte_valid:
  - 0xE0: set e0_seen.
  - 0xF0: set f0_seen.
  - Any other byte with f0_seen=1: no output; clear both flags.
  - Any other byte with f0_seen=0: newKey=1 for one cycle, keyCode=byte, extended=e0_seen; clear both flags.
- frame_err clears e0_seen and f0_seen.
- Latency: newKey rises exactly 2 clk cycles after the cycle in which the stop-bit sample event is detected. frame_err for parity/stop errors uses the same latency. A timeout frame_err rises 1 cycle after the counter reaches its limit.
- newKey and frame_err are never high in the same cycle. A lone prefix byte produces no strobe.
- Bytes arriving back-to-back (minimum PS/2 spacing) are all processed. No buffering beyond one byte is needed because the byte rate is far below the clk rate.

Test Plan:
1. Hold reset=0 mid-frame (after 4 bits), release, then check outputs -> newKey=0, keyCode=0x00, extended=0, frame_err=0; next full frame 0x1C -> newKey, keyCode=0x1C, extended=0.
2. Send E0 then 74 (valid frames, ~12.5 kHz ps2_clk) -> exactly one newKey pulse, keyCode=0x74, extended=1; no strobe for E0.
3. Send E0, F0, 74 -> no newKey, no frame_err; a following 6B -> newKey, keyCode=0x6B, extended=0.
4. Send 0x1C with even parity -> frame_err one cycle, no newKey; then a correct 0x1C -> newKey, keyCode=0x1C. Repeat with stop=0 -> frame_err.
5. Send start plus 3 data bits, then idle TIMEOUT_CYC+10 cycles -> one frame_err pulse, FSM back in IDLE; following valid 0x72 -> newKey, keyCode=0x72.
6. Inject ps2_clk low glitches of FILTER_LEN-2 cycles while idle and mid-frame -> no extra sample events; a valid 0x75 frame with glitches still yields keyCode=0x75 and no frame_err.
